// File: rtl/secp256k1_pkg.sv
// rtl/secp256k1_pkg.sv - shared secp256k1 constants, recoder state type and digit helper
package secp256k1_pkg;

    localparam logic [255:0] CURVE_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] CURVE_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // One digit per bit of a 257-bit working value, hence 257 buffer slots.
    localparam int BUF_DEPTH = 257;
    localparam int BUF_AW    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_RECODE,
        ST_EMIT
    } wnaf_state_t;

    // Largest digit magnitude produced for window width w.
    function automatic int wnaf_digit_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/secp256k1_wnaf_digit_buf.sv
// rtl/secp256k1_wnaf_digit_buf.sv - 257 x W digit register file, sync write, comb read
module secp256k1_wnaf_digit_buf
    import secp256k1_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BUF_AW-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [BUF_AW-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [BUF_DEPTH];

    // Digit store; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < BUF_AW'(BUF_DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range reads (index underflow past slot 0) return zero.
    assign o_rdata = (i_raddr < BUF_AW'(BUF_DEPTH)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/secp256k1_wnaf_recoder.sv
// rtl/secp256k1_wnaf_recoder.sv - scalar to wNAF digit stream, MSB first; optional SECP256K1_WNAF_REDUCE_EN
module secp256k1_wnaf_recoder
    import secp256k1_pkg::*;
#(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [255:0]  k,
    output logic          busy,
    output logic          digit_valid,
    input  logic          digit_ready,
    output logic [W-1:0]  digit,
    output logic          digit_last,
    output logic          k_zero
);

    localparam int RW = 257;

    wnaf_state_t       r_state;
    logic [RW-1:0]     r_work;
    logic [BUF_AW-1:0] r_i;
    logic [BUF_AW-1:0] r_j;
    logic              r_busy;
    logic              r_valid;
    logic [W-1:0]      r_digit;
    logic              r_last;
    logic              r_kzero;

    logic [W-1:0]      w_d;
    logic [RW-1:0]     w_d_ext;
    logic [RW-1:0]     w_sub;
    logic [RW-1:0]     w_next;
    logic [BUF_AW-1:0] w_raddr;
    logic [W-1:0]      w_rdata;
    logic              w_we;

    // An odd value's low W bits read as a signed number are exactly the wNAF digit.
    assign w_d     = r_work[0] ? r_work[W-1:0] : '0;
    assign w_d_ext = {{(RW - W){w_d[W-1]}}, w_d};
    assign w_sub   = r_work - w_d_ext;
    assign w_next  = w_sub >> 1;
    assign w_we    = (r_state == ST_RECODE);
    assign w_raddr = r_j - BUF_AW'(1);

`ifdef SECP256K1_WNAF_REDUCE_EN
    logic [RW-1:0] w_red;
    assign w_red = (r_work >= {1'b0, CURVE_N}) ? (r_work - {1'b0, CURVE_N}) : r_work;
`endif

    secp256k1_wnaf_digit_buf #(.W(W)) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_i),
        .i_wdata (w_d),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Control FSM with registered outputs; the zero check happens on the way into RECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_digit <= '0;
            r_last  <= 1'b0;
            r_kzero <= 1'b0;
        end else begin
            r_kzero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work <= {1'b0, k};
                        r_i    <= '0;
`ifdef SECP256K1_WNAF_REDUCE_EN
                        r_state <= ST_REDUCE;
                        r_busy  <= 1'b1;
`else
                        if (k == '0) begin
                            r_kzero <= 1'b1;
                        end else begin
                            r_state <= ST_RECODE;
                            r_busy  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef SECP256K1_WNAF_REDUCE_EN
                ST_REDUCE: begin
                    if (w_red == '0) begin
                        r_kzero <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_work  <= w_red;
                        r_state <= ST_RECODE;
                    end
                end
`endif
                ST_RECODE: begin
                    r_work <= w_next;
                    r_i    <= r_i + BUF_AW'(1);
                    if (w_next == '0) begin
                        // The digit being written is buf[top]; forward it directly.
                        r_j     <= r_i;
                        r_valid <= 1'b1;
                        r_digit <= w_d;
                        r_last  <= (r_i == '0);
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (r_valid && digit_ready) begin
                        if (r_j == '0) begin
                            r_valid <= 1'b0;
                            r_digit <= '0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_j     <= w_raddr;
                            r_digit <= w_rdata;
                            r_last  <= (r_j == BUF_AW'(1));
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign digit_valid = r_valid;
    assign digit       = r_digit;
    assign digit_last  = r_last;
    assign k_zero      = r_kzero;

endmodule

// File: tb/tb_secp256k1_wnaf_recoder.sv
// tb/tb_secp256k1_wnaf_recoder.sv - scoreboard bench for the wNAF recoder (W=4)
module tb_secp256k1_wnaf_recoder;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] k = '0;
    logic         busy;
    logic         digit_valid;
    logic         digit_ready = 1'b1;
    logic [W-1:0] digit;
    logic         digit_last;
    logic         k_zero;

    exp_t         q[$];
    int           kz_expect = 0;
    int           hs_count = 0;
    int           checks = 0;
    int           failures = 0;

    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_digit = '0;
    logic         prev_last = 1'b0;

    secp256k1_wnaf_recoder #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k           (k),
        .busy        (busy),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .digit_last  (digit_last),
        .k_zero      (k_zero)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled and k_zero pulses.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check1("stall_valid", W'(digit_valid), W'(1));
                check1("stall_digit", digit, prev_digit);
                check1("stall_last", W'(digit_last), W'(prev_last));
            end
            if (digit_valid && digit_ready) begin
                hs_count++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_digit: got %0h last %0b, expected no digit", digit, digit_last);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (digit !== e.d || digit_last !== e.last) begin
                        failures++;
                        $display("FAIL digit: got %0h last %0b, expected %0h last %0b",
                                 digit, digit_last, e.d, e.last);
                    end
                end
            end
            if (k_zero) begin
                checks++;
                if (kz_expect == 0) begin
                    failures++;
                    $display("FAIL unexpected_k_zero: got 1, expected 0");
                end else begin
                    kz_expect--;
                    if (busy !== 1'b0 || digit_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL k_zero_outputs: got busy %0b valid %0b, expected 0 0", busy, digit_valid);
                    end
                end
            end
            stall_prev = digit_valid && !digit_ready;
            prev_digit = digit;
            prev_last  = digit_last;
        end
    end

    task automatic push(input logic [W-1:0] d, input logic last);
        exp_t e;
        e.d = d;
        e.last = last;
        q.push_back(e);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) push('0, 1'b0);
    endtask

    // Issue a start from a posedge+1 position; returns at posedge+1 of the accept edge.
    task automatic issue(input logic [255:0] val);
        start = 1'b1;
        k = val;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(q.size() == 0 && kz_expect == 0 && !busy && !digit_valid) && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 1200) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending digits, expected 0", name, q.size());
        end
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 1200) begin
            failures++;
            $display("FAIL hs_timeout: got %0d handshakes, expected %0d", hs_count, target);
        end
    endtask

    initial begin
        logic [255:0] kv;

        repeat (3) @(posedge clk);
        #1;
        check1("reset_busy", W'(busy), '0);
        check1("reset_valid", W'(digit_valid), '0);
        check1("reset_digit", digit, '0);
        check1("reset_last", W'(digit_last), '0);
        check1("reset_kzero", W'(k_zero), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // k=1 -> +1
        push(4'h1, 1'b1);
        issue(256'd1);
        check1("busy_after_accept", W'(busy), W'(1));
        wait_done("k1");
        check1("idle_busy", W'(busy), '0);
        check1("idle_valid", W'(digit_valid), '0);

        // k=7 -> 7
        push(4'h7, 1'b1);
        issue(256'd7);
        wait_done("k7");

        // k=255 -> 1, seven zeros, -1
        push(4'h1, 1'b0); push_zeros(7); push(4'hF, 1'b1);
        issue(256'd255);
        wait_done("k255");

        // k=9 -> 1,0,0,0,-7 ; k=23 -> 1,0,0,0,7 (back to back)
        push(4'h1, 1'b0); push_zeros(3); push(4'h9, 1'b1);
        issue(256'd9);
        wait_done("k9");
        push(4'h1, 1'b0); push_zeros(3); push(4'h7, 1'b1);
        issue(256'd23);
        wait_done("k23");

        // k=0 -> k_zero only
        kz_expect = 1;
        issue(256'd0);
`ifdef SECP256K1_WNAF_REDUCE_EN
        check1("kzero_early", W'(k_zero), '0);
        @(posedge clk);
        #1;
`endif
        check1("kzero_timing", W'(k_zero), W'(1));
        check1("kzero_busy", W'(busy), '0);
        wait_done("k0");

        // k=255 with a 5-cycle stall after the third digit
        push(4'h1, 1'b0); push_zeros(7); push(4'hF, 1'b1);
        issue(256'd255);
        wait_hs(hs_count + 3);
        digit_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check1("stalled_digit", digit, '0);
        digit_ready = 1'b1;
        wait_done("stall");

        // k=2^255 -> 1 followed by 255 zeros
        kv = '0;
        kv[255] = 1'b1;
        push(4'h1, 1'b0); push_zeros(254); push('0, 1'b1);
        issue(kv);
        wait_done("k2p255");

        // k=2^256-1 -> 1, 255 zeros, -1 (full 257-digit buffer)
        kv = '1;
        push(4'h1, 1'b0); push_zeros(255); push(4'hF, 1'b1);
        issue(kv);
        wait_done("kmax");

        // Reset mid-EMIT, then k=3 -> 3
        push(4'h1, 1'b0); push_zeros(7); push(4'hF, 1'b1);
        issue(256'd255);
        wait_hs(hs_count + 2);
        rst = 1'b1;
        q.delete();
        #1;
        check1("rst_busy", W'(busy), '0);
        check1("rst_valid", W'(digit_valid), '0);
        check1("rst_digit", digit, '0);
        check1("rst_last", W'(digit_last), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(4'h3, 1'b1);
        issue(256'd3);
        wait_done("k3");

`ifdef SECP256K1_WNAF_REDUCE_EN
        // k=n+1 reduces to 1
        push(4'h1, 1'b1);
        issue(256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364142);
        wait_done("kn1");
`endif

        repeat (3) @(posedge clk);
        #1;
        check1("final_queue_empty", W'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
